bp_cce_fetch_unit: RTL
======================

Name: bp_cce_fetch_unit

Overview:
- Parametrised CCE instruction fetch unit: PC register, next-PC logic and instruction RAM.
- Supports arbitrary instruction width split into N config-link chunks, with config-link read-back of any chunk.
- Adds a debug halt/resume mode and re-entry to programming when freeze_i reasserts.
- Sits between the config link and the CCE decode stage; one instruction per cycle in steady state.

Parameters:
- inst_ram_els_p, 256, instruction RAM depth (any value ≥2, not required to be a power of 2)
- inst_width_p, 48, instruction width in bits
- cfg_link_addr_width_p, 16, config address width
- cfg_link_data_width_p, 32, config data width (D)
- Derived: chunks_lp = ceil(inst_width_p/D); chunk_sel_w_lp = BSG_SAFE_CLOG2(chunks_lp); addr_w_lp = BSG_SAFE_CLOG2(inst_ram_els_p)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous, active-low reset
- freeze_i  in  1  high: RAM programmable via config link, fetch disabled
- config_addr_i  in  cfg_link_addr_width_p  [MSB]=RAM select; [chunk_sel_w_lp-1:0]=chunk; next addr_w_lp bits=RAM index
- config_data_i  in  D  write data
- config_v_i  in  1  request valid
- config_w_i  in  1  1=write, 0=read
- config_ready_o  out  1  request accepted when v&ready
- config_data_o  out  D  read response data
- config_v_o  out  1  read response valid
- config_ready_i  in  1  response consumed when v&ready
- stall_i  in  1  hold current instruction
- branch_i  in  1  redirect to branch_target_i
- branch_target_i  in  addr_w_lp  branch target index
- halt_req_i  in  1  debug halt request (level)
- inst_o  out  inst_width_p  instruction for decode
- inst_v_o  out  1  inst_o valid
- pc_o  out  addr_w_lp  index of inst_o
- halted_o  out  1  unit is in HALT

Behaviour:
- Clocking and RAM: single clock. The RAM is a 1rw sync RAM with bit-mask write; read data is available the cycle after the access. RAM contents are not cleared by reset.
- Reset: when reset_n_i=0 in any state (including mid-read-response or mid-fetch), the next state is RESET. inst_v_o, config_v_o, config_ready_o, halted_o, pc_o and config_data_o read 0 during and after reset. inst_o is don't-care while inst_v_o=0.
- States: RESET, INIT, INIT_RD, FETCH_1, FETCH, HALT.
- RESET: goes to INIT on the first cycle with reset_n_i=1.
- INIT: config_ready_o=1.
  - Write handshake with RAM select=1 and chunk<chunks_lp: same-cycle masked write of bits [chunk*D +: D], truncated at inst_width_p (last chunk zero-extended).
  - Write with RAM select=0 or an out-of-range chunk: accepted and dropped.
  - Read handshake: RAM read is issued that cycle; go to INIT_RD.
  - No request and freeze_i=0: go to FETCH_1.
- INIT_RD: config_ready_o=0; config_v_o=1 from the cycle after the read handshake.
  - Data = selected chunk, zero-padded. Data = 0 for RAM select=0 or an out-of-range chunk.
  - Response data is registered so it stays stable while config_ready_i=0.
  - On config_ready_i=1, return to INIT.
- FETCH_1: issue RAM read of index 0; ex_pc←0; next_pc←1; go to FETCH. inst_v_o=1 from the next cycle.
- FETCH: inst_v_o=1, inst_o=RAM output, pc_o=ex_pc. Priority each cycle:
  - stall_i: re-read ex_pc; ex_pc and next_pc are held.
  - else branch_i: read branch_target_i; ex_pc←target; next_pc←target+1.
  - else: read next_pc; ex_pc←next_pc; next_pc←next_pc+1.
  - All increments wrap from inst_ram_els_p-1 to 0.
  - branch_target_i ≥ inst_ram_els_p is reduced modulo inst_ram_els_p.
- Halt entry (FETCH): if halt_req_i=1 and stall_i=0, apply the branch/sequential update above, then go to HALT. A coincident branch is committed first.
- HALT: inst_v_o=0, halted_o=1, no RAM access, ex_pc held.
  - freeze_i=1: go to INIT (reprogramming allowed).
  - else halt_req_i=0: re-read ex_pc and go to FETCH; inst_v_o=1 the next cycle with pc_o=ex_pc.
- Freeze in FETCH: freeze_i=1 → INIT with inst_v_o=0 next cycle. A later exit from INIT restarts at index 0 via FETCH_1.
- Config inputs are ignored outside INIT.

Test Plan:
- Config fill: reset, freeze_i=1; write chunks 0 and 1 of index 3 with 0xDEADBEEF / 0x1234; read both back → config_data_o=0xDEADBEEF, then 0x00001234; read chunk 2 → 0.
- Backpressured read: hold config_ready_i=0 for 5 cycles → config_v_o=1 with stable data and config_ready_o=0; return to INIT the cycle after ready.
- Fetch sequence: program indices 0..4, drop freeze_i → inst_v_o rises 2 cycles after leaving INIT; pc_o=0,1,2,3,4 on consecutive cycles; with inst_ram_els_p=5, the next pc_o=0.
- Stall/branch: stall_i at pc_o=2 for 3 cycles → pc_o holds 2; stall_i+branch_i(7) together → stall wins; branch_i alone → next pc_o=7, then 8.
- Halt: halt_req_i at pc_o=4 with branch_i(10) → HALT, halted_o=1, inst_v_o=0; release → pc_o=10 the cycle after resume, inst_v_o=1.
- Reset mid-op: reset_n_i=0 during INIT_RD and again in FETCH → all outputs 0 next cycle; previously written RAM data still reads back after re-init.

Source files
------------

// File: rtl/bp_cce_fetch_unit.sv
// CCE instruction fetch unit: config-link programmable instruction RAM, PC/next-PC
// tracking, stall/branch redirect and a debug halt/resume mode.
module bp_cce_fetch_unit #(
  parameter int inst_ram_els_p        = 256,
  parameter int inst_width_p          = 48,
  parameter int cfg_link_addr_width_p = 16,
  parameter int cfg_link_data_width_p = 32,
  localparam int chunks_lp      = (inst_width_p + cfg_link_data_width_p - 1) / cfg_link_data_width_p,
  localparam int chunk_sel_w_lp = (chunks_lp == 1) ? 1 : $clog2(chunks_lp),
  localparam int addr_w_lp      = (inst_ram_els_p == 1) ? 1 : $clog2(inst_ram_els_p)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             freeze_i,
  input  logic [cfg_link_addr_width_p-1:0] config_addr_i,
  input  logic [cfg_link_data_width_p-1:0] config_data_i,
  input  logic                             config_v_i,
  input  logic                             config_w_i,
  output logic                             config_ready_o,
  output logic [cfg_link_data_width_p-1:0] config_data_o,
  output logic                             config_v_o,
  input  logic                             config_ready_i,
  input  logic                             stall_i,
  input  logic                             branch_i,
  input  logic [addr_w_lp-1:0]             branch_target_i,
  input  logic                             halt_req_i,
  output logic [inst_width_p-1:0]          inst_o,
  output logic                             inst_v_o,
  output logic [addr_w_lp-1:0]             pc_o,
  output logic                             halted_o
);

  localparam int          data_w_lp   = cfg_link_data_width_p;
  localparam logic [31:0] els_lp      = inst_ram_els_p;
  localparam logic [31:0] chunks_u_lp = chunks_lp;

  typedef enum logic [2:0] {S_RESET, S_INIT, S_INIT_RD, S_FETCH_1, S_FETCH, S_HALT} state_e;

  state_e                    state_q;
  logic [addr_w_lp-1:0]      ex_pc_q, next_pc_q;
  logic                      inst_v_q, halted_q, config_ready_q, config_v_q;
  logic                      rd_ok_q;
  logic [chunk_sel_w_lp-1:0] rd_chunk_q;

  logic                      cfg_sel, cfg_ok, cfg_hs;
  logic [chunk_sel_w_lp-1:0] cfg_chunk;
  logic [addr_w_lp-1:0]      cfg_idx, br_tgt;

  logic                      ram_v, ram_w;
  logic [addr_w_lp-1:0]      ram_addr;
  logic [inst_width_p-1:0]   ram_wdata, ram_wmask, ram_data_q;
  logic [inst_width_p-1:0]   mem [inst_ram_els_p];
  logic [data_w_lp-1:0]      rd_chunks [chunks_lp];

  function automatic logic [addr_w_lp-1:0] pc_inc(input logic [addr_w_lp-1:0] a);
    return (32'(a) == els_lp - 32'd1) ? '0 : a + addr_w_lp'(1);
  endfunction

  assign cfg_sel   = config_addr_i[cfg_link_addr_width_p-1];
  assign cfg_chunk = config_addr_i[chunk_sel_w_lp-1:0];
  assign cfg_idx   = config_addr_i[chunk_sel_w_lp +: addr_w_lp];
  assign cfg_ok    = cfg_sel && (32'(cfg_chunk) < chunks_u_lp) && (32'(cfg_idx) < els_lp);
  assign cfg_hs    = config_v_i && config_ready_q;
  assign br_tgt    = addr_w_lp'(32'(branch_target_i) % els_lp);

  if (cfg_link_addr_width_p - 1 > chunk_sel_w_lp + addr_w_lp) begin : g_unused_addr
    logic unused_addr;
    assign unused_addr = ^config_addr_i[cfg_link_addr_width_p-2:chunk_sel_w_lp+addr_w_lp];
  end

  // Each chunk slot is clipped to the instruction width; the last one may be narrower than D.
  for (genvar gi = 0; gi < chunks_lp; gi++) begin : g_chunk
    localparam int lo_lp = gi * data_w_lp;
    localparam int w_lp  = (inst_width_p - lo_lp < data_w_lp) ? inst_width_p - lo_lp : data_w_lp;
    assign ram_wdata[lo_lp +: w_lp] = config_data_i[w_lp-1:0];
    assign ram_wmask[lo_lp +: w_lp] = {w_lp{cfg_chunk == chunk_sel_w_lp'(gi)}};
    assign rd_chunks[gi]            = data_w_lp'(ram_data_q[lo_lp +: w_lp]);
  end

  always_comb begin
    ram_v    = 1'b0;
    ram_w    = 1'b0;
    ram_addr = '0;
    case (state_q)
      S_INIT: begin
        ram_v    = cfg_hs && cfg_ok;
        ram_w    = config_w_i;
        ram_addr = cfg_idx;
      end
      S_FETCH_1: ram_v = 1'b1;
      S_FETCH: begin
        ram_v    = !freeze_i;
        ram_addr = stall_i ? ex_pc_q : (branch_i ? br_tgt : next_pc_q);
      end
      S_HALT: begin
        ram_v    = !freeze_i && !halt_req_i;
        ram_addr = ex_pc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (ram_v) begin
      if (ram_w) begin
        for (int b = 0; b < inst_width_p; b++) begin
          if (ram_wmask[b]) mem[ram_addr][b] <= ram_wdata[b];
        end
      end else begin
        ram_data_q <= mem[ram_addr];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q        <= S_RESET;
      ex_pc_q        <= '0;
      next_pc_q      <= '0;
      inst_v_q       <= 1'b0;
      halted_q       <= 1'b0;
      config_ready_q <= 1'b0;
      config_v_q     <= 1'b0;
      rd_ok_q        <= 1'b0;
      rd_chunk_q     <= '0;
    end else begin
      inst_v_q       <= 1'b0;
      halted_q       <= 1'b0;
      config_ready_q <= 1'b0;
      config_v_q     <= 1'b0;
      case (state_q)
        S_RESET: begin
          state_q        <= S_INIT;
          config_ready_q <= 1'b1;
        end
        S_INIT: begin
          if (cfg_hs && !config_w_i) begin
            state_q    <= S_INIT_RD;
            config_v_q <= 1'b1;
            rd_ok_q    <= cfg_ok;
            rd_chunk_q <= cfg_ok ? cfg_chunk : '0;
          end else if (!config_v_i && !freeze_i) begin
            state_q <= S_FETCH_1;
          end else begin
            config_ready_q <= 1'b1;
          end
        end
        S_INIT_RD: begin
          if (config_ready_i) begin
            state_q        <= S_INIT;
            config_ready_q <= 1'b1;
          end else begin
            config_v_q <= 1'b1;
          end
        end
        S_FETCH_1: begin
          ex_pc_q   <= '0;
          next_pc_q <= pc_inc('0);
          state_q   <= S_FETCH;
          inst_v_q  <= 1'b1;
        end
        S_FETCH: begin
          if (freeze_i) begin
            state_q        <= S_INIT;
            config_ready_q <= 1'b1;
          end else begin
            if (!stall_i) begin
              ex_pc_q   <= ram_addr;
              next_pc_q <= pc_inc(ram_addr);
            end
            // A coincident branch is committed above before entering HALT.
            if (halt_req_i && !stall_i) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              inst_v_q <= 1'b1;
            end
          end
        end
        S_HALT: begin
          if (freeze_i) begin
            state_q        <= S_INIT;
            config_ready_q <= 1'b1;
          end else if (!halt_req_i) begin
            state_q  <= S_FETCH;
            inst_v_q <= 1'b1;
          end else begin
            halted_q <= 1'b1;
          end
        end
        default: state_q <= S_RESET;
      endcase
    end
  end

  assign config_ready_o = config_ready_q;
  assign config_v_o     = config_v_q;
  assign config_data_o  = (config_v_q && rd_ok_q) ? rd_chunks[rd_chunk_q] : '0;
  assign inst_o         = ram_data_q;
  assign inst_v_o       = inst_v_q;
  assign pc_o           = ex_pc_q;
  assign halted_o       = halted_q;

endmodule
